mem_load_bridge: RTL

//   Consumes the testbench memory-load bus (mem_en/mem_rd_wr/mem_add/mem_data) and turns it into

---
 rtl/mem_load_bridge_if.sv | 34 +++
 rtl/mem_load_bridge.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mem_load_bridge_if.sv
// Bus bundle between the memory-load driver, the bridge and the single-port memory.
// The bridge takes the slave view; the driver/memory side takes the master view.
interface mem_load_bridge_if #(
  parameter int ADDR_W = 10
);
  logic              mem_en;
  logic              mem_rd_wr;
  logic [31:0]       mem_add;
  logic [31:0]       mem_data;
  logic              core_hold;
  logic              imem_en;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       imem_rdata;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              fifo_full;
  logic              idle;
  logic              err_ovf;
  logic              err_align;

  modport master (
    output mem_en, mem_rd_wr, mem_add, mem_data, core_hold, imem_rdata,
    input  imem_en, imem_we, imem_addr, imem_wdata, rd_valid, rd_data,
           fifo_full, idle, err_ovf, err_align
  );

  modport slave (
    input  mem_en, mem_rd_wr, mem_add, mem_data, core_hold, imem_rdata,
    output imem_en, imem_we, imem_addr, imem_wdata, rd_valid, rd_data,
           fifo_full, idle, err_ovf, err_align
  );
endinterface

// File: rtl/mem_load_bridge.sv
// Bridges the memory-load bus onto the shared instruction/data memory: buffered writes,
// one-deep pending read, all memory traffic yields to the core while core_hold is high.
module mem_load_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 10
) (
  input logic              clock,
  input logic              reset_n,
  mem_load_bridge_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ_REQ, S_READ_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              rd_pending;
  logic [ADDR_W-1:0] rd_addr;
  logic              err_ovf_q;
  logic              err_align_q;

  logic [ADDR_W-1:0] word_addr;
  logic              misaligned;
  logic              fifo_empty;
  logic              full;
  logic              pop;
  logic              wr_req;
  logic              rd_req;
  logic              push;
  logic              unused_addr_bits;

  assign word_addr        = bus.mem_add[ADDR_W+1:2];
  assign unused_addr_bits = &{1'b0, bus.mem_add[31:ADDR_W+2]};
  assign misaligned       = bus.mem_en && (bus.mem_add[1:0] != 2'b00);
  assign fifo_empty       = (count == '0);
  assign full             = (count == CNT_W'(FIFO_DEPTH));
  // The head leaves the FIFO on the same edge the FSM enters (or stays in) WRITE.
  assign pop    = ((state == S_IDLE) || (state == S_WRITE)) && !bus.core_hold && !fifo_empty;
  assign wr_req = bus.mem_en && bus.mem_rd_wr && !misaligned;
  assign rd_req = bus.mem_en && !bus.mem_rd_wr && !misaligned;
  assign push   = wr_req && (!full || pop);

  assign bus.fifo_full = full;
  assign bus.idle      = fifo_empty && !rd_pending && (state == S_IDLE);
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_align = err_align_q;

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= word_addr;
      fifo_data[wr_ptr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_pending  <= 1'b0;
      rd_addr     <= '0;
      err_ovf_q   <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (state == S_READ_WAIT) rd_pending <= 1'b0;
      if (rd_req && !rd_pending) begin
        rd_pending <= 1'b1;
        rd_addr    <= word_addr;
      end
      if ((wr_req && !push) || (rd_req && rd_pending)) err_ovf_q <= 1'b1;
      if (misaligned) err_align_q <= 1'b1;
    end
  end

  // imem_* are registered together with the state, so they are valid for the whole state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      bus.imem_en    <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.rd_valid   <= 1'b0;
      bus.rd_data    <= '0;
    end else begin
      bus.rd_valid <= 1'b0;
      case (state)
        S_IDLE, S_WRITE: begin
          if (pop) begin
            state          <= S_WRITE;
            bus.imem_en    <= 1'b1;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= fifo_addr[rd_ptr];
            bus.imem_wdata <= fifo_data[rd_ptr];
          end else if (!bus.core_hold && rd_pending) begin
            state         <= S_READ_REQ;
            bus.imem_en   <= 1'b1;
            bus.imem_we   <= 1'b0;
            bus.imem_addr <= rd_addr;
          end else begin
            state       <= S_IDLE;
            bus.imem_en <= 1'b0;
            bus.imem_we <= 1'b0;
          end
        end
        S_READ_REQ: begin
          state       <= S_READ_WAIT;
          bus.imem_en <= 1'b0;
          bus.imem_we <= 1'b0;
        end
        S_READ_WAIT: begin
          state        <= S_IDLE;
          bus.rd_data  <= bus.imem_rdata;
          bus.rd_valid <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          bus.imem_en <= 1'b0;
          bus.imem_we <= 1'b0;
        end
      endcase
    end
  end
endmodule
